// File: rtl/reg_ready_table_pkg.sv
// Shared definitions for the physical-register ready scoreboard.
//   DEF_NUM_REGS  default number of physical tags (power of 2)
//   DEF_TAG_W     tag width matching DEF_NUM_REGS
//   tag_t         physical tag type at the default size
//   init_ready()  reset readiness of one tag; tag 0 is always ready
package reg_ready_table_pkg;

  localparam int DEF_NUM_REGS = 64;
  localparam int DEF_TAG_W    = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_TAG_W-1:0] tag_t;

  function automatic logic init_ready(input int tag, input int init_cnt);
    return (tag == 0) || (tag < init_cnt);
  endfunction

endpackage

// File: rtl/reg_ready_table_popcount.sv
// Combinational population count of the ready table, built as a pairwise
// adder tree. The parent registers the result.
// Ports:
//   bits_in  in   N      vector to count
//   count    out  CNT_W  number of ones in bits_in
module reg_ready_table_popcount #(
  parameter int N     = 64,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     bits_in,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] node [N];

  // In-place tree: after the stride-s pass, node[i] (i a multiple of 2s)
  // holds the sum of bits i..i+2s-1. N must be a power of 2.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      node[i] = CNT_W'(bits_in[i]);
    end
    for (int s = 1; s < N; s = s * 2) begin
      for (int i = 0; i < N; i = i + 2 * s) begin
        node[i] = node[i] + node[i + s];
      end
    end
    count = node[0];
  end

endmodule

// File: rtl/reg_ready_table.sv
// Physical-register readiness scoreboard for the issue stage.
// One ready bit per tag, multi-port combinational readout, writeback set
// ports, rename clear ports, single checkpoint/restore shadow for flush, and
// a registered ready count for the allocator.
// Ports:
//   clk         in   1                 clock, rising edge
//   reset       in   1                 synchronous, active-low
//   setEn       in   NUM_SET           per-port set enable
//   setSel      in   NUM_SET*TAG_W     set tags, port k at [k*TAG_W +: TAG_W]
//   clrEn       in   NUM_CLR           per-port clear enable
//   clrSel      in   NUM_CLR*TAG_W     clear tags, same packing
//   checkpoint  in   1                 capture next-state table into shadow
//   restore     in   1                 reload table from shadow
//   readSel     in   NUM_READ*TAG_W    read tags, same packing
//   readData    out  NUM_READ          ready bit per read port
//   readyCount  out  CNT_W             registered count of ready tags
module reg_ready_table
  import reg_ready_table_pkg::*;
#(
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int TAG_W      = $clog2(NUM_REGS),
  parameter int NUM_READ   = 18,
  parameter int NUM_SET    = 4,
  parameter int NUM_CLR    = 4,
  parameter int INIT_READY = 32,
  parameter bit BYPASS     = 1'b1,
  parameter int CNT_W      = $clog2(NUM_REGS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SET-1:0]        setEn,
  input  logic [NUM_SET*TAG_W-1:0]  setSel,
  input  logic [NUM_CLR-1:0]        clrEn,
  input  logic [NUM_CLR*TAG_W-1:0]  clrSel,
  input  logic                      checkpoint,
  input  logic                      restore,
  input  logic [NUM_READ*TAG_W-1:0] readSel,
  output logic [NUM_READ-1:0]       readData,
  output logic [CNT_W-1:0]          readyCount
);

  logic [NUM_REGS-1:0] init_vec;
  logic [NUM_REGS-1:0] table_q, table_d;
  logic [NUM_REGS-1:0] shadow_q, shadow_d;
  logic [NUM_REGS-1:0] set_vec, clr_vec, nxt_vec;
  logic [CNT_W-1:0]    count_q, count_d;

  always_comb begin
    for (int t = 0; t < NUM_REGS; t++) begin
      init_vec[t] = init_ready(t, INIT_READY);
    end
  end

  // Decode the set/clear ports into per-tag hit vectors. Duplicate tags
  // simply hit the same bit. Tag 0 is masked so it can never change.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int k = 0; k < NUM_SET; k++) begin
      if (setEn[k]) set_vec[setSel[k*TAG_W +: TAG_W]] = 1'b1;
    end
    for (int k = 0; k < NUM_CLR; k++) begin
      if (clrEn[k]) clr_vec[clrSel[k*TAG_W +: TAG_W]] = 1'b1;
    end
    set_vec[0] = 1'b0;
    clr_vec[0] = 1'b0;
  end

  // Clear is applied after set, so it wins on the same tag.
  always_comb begin
    nxt_vec    = (table_q | set_vec) & ~clr_vec;
    nxt_vec[0] = 1'b1;
  end

  // Restore takes priority: shadow plus this cycle's writebacks (a tag
  // written back during the flush cycle must not be lost); clears belong to
  // the squashed path and are dropped, and the shadow is left alone.
  always_comb begin
    table_d  = nxt_vec;
    shadow_d = shadow_q;
    if (restore) begin
      table_d  = shadow_q | set_vec;
      table_d[0] = 1'b1;
    end else if (checkpoint) begin
      shadow_d = nxt_vec;
    end
  end

  reg_ready_table_popcount #(
    .N     (NUM_REGS),
    .CNT_W (CNT_W)
  ) u_popcount (
    .bits_in (table_q),
    .count   (count_d)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      table_q  <= init_vec;
      shadow_q <= init_vec;
      count_q  <= CNT_W'(INIT_READY);
    end else begin
      table_q  <= table_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  assign readyCount = count_q;

  // Read mux per port. With bypass, a tag being written back this cycle
  // reads ready even if a clear hits it too; clears only show after the edge.
  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [TAG_W-1:0] sel;
    assign sel = readSel[i*TAG_W +: TAG_W];
    if (BYPASS) begin : g_byp
      assign readData[i] = table_q[sel] | set_vec[sel];
    end else begin : g_nobyp
      assign readData[i] = table_q[sel];
    end
  end

endmodule
